// File: rtl/wave_seq_pkg.sv
// wave_seq_pkg: shared state type and width constants for the waveform
// sample-memory address sequencer.
package wave_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Cycles spent flushing the memory/sample pipeline after stop.
  localparam int DRAIN_LEN  = 2;

  localparam int MEM_ADDR_W = 12;
  localparam int SAMPLE_W   = 12;

endpackage

// File: rtl/phase_accumulator.sv
// phase_accumulator: one channel's step register, optional start-offset
// register and phase accumulator. The top address bits of the accumulator
// are exported as the memory index for this channel.
// Optional feature macro: WAVE_SEQ_PHASE_OFFSET_EN (start phase from offset).
module phase_accumulator #(
  parameter int ACC_W      = 24,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  advance,
  input  logic                  cfg_we,
  input  logic [ACC_W-1:0]      cfg_step,
`ifdef WAVE_SEQ_PHASE_OFFSET_EN
  input  logic [ACC_W-1:0]      cfg_offset,
`endif
  output logic [DEPTH_LOG2-1:0] phase_addr
);

  logic [ACC_W-1:0] step;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] start_phase;

`ifdef WAVE_SEQ_PHASE_OFFSET_EN
  logic [ACC_W-1:0] offset;

  // Offset is captured together with the step on every config write.
  always_ff @(posedge clk) begin
    if (rst) begin
      offset <= '0;
    end else if (cfg_we) begin
      offset <= cfg_offset;
    end
  end

  assign start_phase = offset;
`else
  assign start_phase = '0;
`endif

  // Step register; a write coinciding with an advance only affects later advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      step <= '0;
    end else if (cfg_we) begin
      step <= cfg_step;
    end
  end

  // Accumulator: reload on start, otherwise add the step with silent wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= start_phase;
    end else if (advance) begin
      acc <= acc + step;
    end
  end

  assign phase_addr = acc[ACC_W-1 -: DEPTH_LOG2];

endmodule

// File: rtl/wave_sequencer.sv
// wave_sequencer: round-robin address sequencer for the shared waveform
// sample memory. One issue per RUN cycle; the returning sample is tagged
// with its channel two cycles later.
// Optional feature macro: WAVE_SEQ_PHASE_OFFSET_EN (adds cfg_offset port).
//
//   state | meaning
//   IDLE  | no issues; start loads accumulators and enters RUN
//   RUN   | issue channel ch_ptr every cycle; stop enters DRAIN (no issue)
//   DRAIN | DRAIN_LEN cycles without issues while the pipeline empties
module wave_sequencer
  import wave_seq_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int ACC_W      = 24,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        cfg_we,
  input  logic [$clog2(CHANNELS)-1:0] cfg_ch,
  input  logic [ACC_W-1:0]            cfg_step,
`ifdef WAVE_SEQ_PHASE_OFFSET_EN
  input  logic [ACC_W-1:0]            cfg_offset,
`endif
  output logic [MEM_ADDR_W-1:0]       mem_address,
  input  logic [SAMPLE_W-1:0]         mem_sample,
  output logic [SAMPLE_W-1:0]         sample_out,
  output logic [$clog2(CHANNELS)-1:0] sample_ch,
  output logic                        sample_valid,
  output logic                        busy
);

  localparam int CH_W = $clog2(CHANNELS);

  state_t                state;
  state_t                state_nx;
  logic [1:0]            drain_cnt;
  logic [CH_W-1:0]       ch_ptr;
  logic                  start_ok;
  logic                  issue;
  logic [DEPTH_LOG2-1:0] phase_addr [CHANNELS];
  logic [MEM_ADDR_W-1:0] issue_addr;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic                  v1;
  logic [CH_W-1:0]       ch1;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    phase_accumulator #(
      .ACC_W      (ACC_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_acc (
      .clk        (clk),
      .rst        (rst),
      .load       (start_ok),
      .advance    (issue && (ch_ptr == CH_W'(c))),
      .cfg_we     (cfg_we && (cfg_ch == CH_W'(c))),
      .cfg_step   (cfg_step),
`ifdef WAVE_SEQ_PHASE_OFFSET_EN
      .cfg_offset (cfg_offset),
`endif
      .phase_addr (phase_addr[c])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, start acceptance and issue decision; stop beats start in IDLE.
  always_comb begin
    state_nx = state;
    start_ok = 1'b0;
    issue    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          start_ok = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_nx = DRAIN;
        end else begin
          issue = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Drain timer: loaded on stop, counts down to its terminal value in DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt <= '0;
    end else if (state == RUN && stop) begin
      drain_cnt <= 2'(DRAIN_LEN - 1);
    end else if (state == DRAIN && drain_cnt != '0) begin
      drain_cnt <= drain_cnt - 1'b1;
    end
  end

  // Round-robin channel pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_ptr <= '0;
    end else if (start_ok) begin
      ch_ptr <= '0;
    end else if (issue) begin
      ch_ptr <= (ch_ptr == CH_W'(CHANNELS - 1)) ? '0 : ch_ptr + 1'b1;
    end
  end

  // Zero-extended memory index of the channel currently being issued.
  always_comb begin
    issue_addr = '0;
    issue_addr[DEPTH_LOG2-1:0] = phase_addr[ch_ptr];
  end

  // Last issued address, held on the bus whenever nothing is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else if (issue) begin
      addr_q <= issue_addr;
    end
  end

  assign mem_address = issue ? issue_addr : addr_q;
  assign busy        = (state != IDLE);

  // Two-stage valid/channel pipeline matching the one-cycle memory read.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1           <= 1'b0;
      ch1          <= '0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_out   <= '0;
    end else begin
      v1           <= issue;
      sample_valid <= v1;
      if (issue) begin
        ch1 <= ch_ptr;
      end
      if (v1) begin
        sample_ch  <= ch1;
        sample_out <= mem_sample;
      end
    end
  end

endmodule

// File: tb/tb_wave_sequencer.sv
// tb_wave_sequencer: directed plus random stimulus against a behavioural
// model; expected samples are queued at issue time and popped by a monitor.
module tb_wave_sequencer;

  localparam int CHANNELS   = 2;
  localparam int ACC_W      = 8;
  localparam int DEPTH_LOG2 = 5;
  localparam int CH_W       = 1;
  localparam int ACC_MOD    = 1 << ACC_W;
  localparam int SHIFT      = ACC_W - DEPTH_LOG2;
`ifdef WAVE_SEQ_PHASE_OFFSET_EN
  localparam bit OFFSET_EN  = 1'b1;
`else
  localparam bit OFFSET_EN  = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             cfg_we = 1'b0;
  logic [CH_W-1:0]  cfg_ch = '0;
  logic [ACC_W-1:0] cfg_step = '0;
`ifdef WAVE_SEQ_PHASE_OFFSET_EN
  logic [ACC_W-1:0] cfg_offset = '0;
`endif
  logic [11:0]      mem_address;
  logic [11:0]      mem_sample = '0;
  logic [11:0]      sample_out;
  logic [CH_W-1:0]  sample_ch;
  logic             sample_valid;
  logic             busy;

  logic [11:0]      mem [4096];

  typedef struct {
    int ch;
    int data;
  } exp_t;

  exp_t exp_q[$];
  int   hist_addr[$];
  int   acc_m  [CHANNELS];
  int   step_m [CHANNELS];
  int   offs_m [CHANNELS];
  bit   running;
  int   drain_left;
  int   ptr;
  int   last_addr;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_issued = 0;
  int   n_seen   = 0;
  int   exp_rr   [6] = '{0, 0, 1, 2, 2, 4};
  int   exp_wrap [4] = '{0, 31, 30, 29};
  int   exp_col  [4] = '{0, 2, 6, 10};

  wave_sequencer #(
    .CHANNELS   (CHANNELS),
    .ACC_W      (ACC_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_step     (cfg_step),
`ifdef WAVE_SEQ_PHASE_OFFSET_EN
    .cfg_offset   (cfg_offset),
`endif
    .mem_address  (mem_address),
    .mem_sample   (mem_sample),
    .sample_out   (sample_out),
    .sample_ch    (sample_ch),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read sample memory.
  always @(posedge clk) mem_sample <= mem[mem_address];

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Monitor: every presented sample must match the oldest outstanding issue.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst == 1'b0 && sample_valid == 1'b1) begin
      n_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_sample_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sample_ch", int'(sample_ch), e.ch);
        chk("sample_out", int'(sample_out), e.data);
      end
    end
  end

  // One clock cycle of stimulus plus the model's view of that cycle.
  task automatic cyc(input bit st, input bit sp, input bit we, input int ch,
                     input int stp, input int off);
    int   a;
    exp_t e;
    @(posedge clk);
    #1;
    start    = st;
    stop     = sp;
    cfg_we   = we;
    cfg_ch   = CH_W'(ch);
    cfg_step = ACC_W'(stp);
`ifdef WAVE_SEQ_PHASE_OFFSET_EN
    cfg_offset = ACC_W'(off);
`endif
    #1;
    chk("busy", int'(busy), (running || drain_left > 0) ? 1 : 0);
    if (running && !sp) begin
      a = acc_m[ptr] >> SHIFT;
      chk("mem_address", int'(mem_address), a);
      e.ch   = ptr;
      e.data = int'(mem[a]);
      exp_q.push_back(e);
      hist_addr.push_back(a);
      last_addr = a;
      n_issued++;
      acc_m[ptr] = (acc_m[ptr] + step_m[ptr]) % ACC_MOD;
      ptr = (ptr + 1) % CHANNELS;
    end else begin
      chk("mem_address_hold", int'(mem_address), last_addr);
    end
    if (running && sp) begin
      running    = 1'b0;
      drain_left = 2;
    end else if (drain_left > 0) begin
      drain_left--;
    end else if (!running && st && !sp) begin
      running = 1'b1;
      ptr     = 0;
      hist_addr.delete();
      for (int c = 0; c < CHANNELS; c++) acc_m[c] = OFFSET_EN ? offs_m[c] : 0;
    end
    if (we) begin
      step_m[ch] = stp % ACC_MOD;
      offs_m[ch] = off % ACC_MOD;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rst    = 1'b1;
      start  = 1'b0;
      stop   = 1'b0;
      cfg_we = 1'b0;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_issued -= exp_q.size();
    exp_q.delete();
    running    = 1'b0;
    drain_left = 0;
    ptr        = 0;
    last_addr  = 0;
    for (int c = 0; c < CHANNELS; c++) begin
      acc_m[c]  = 0;
      step_m[c] = 0;
      offs_m[c] = 0;
    end
    #1;
    chk("rst_mem_address", int'(mem_address), 0);
    chk("rst_sample_out", int'(sample_out), 0);
    chk("rst_sample_ch", int'(sample_ch), 0);
    chk("rst_sample_valid", int'(sample_valid), 0);
    chk("rst_busy", int'(busy), 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom);
    running = 1'b0;
    drain_left = 0;
    ptr = 0;
    last_addr = 0;

    do_reset(3);

    // Round-robin with steps 8 and 16.
    cyc(1'b0, 1'b0, 1'b1, 0, 8, 0);
    cyc(1'b0, 1'b0, 1'b1, 1, 16, 0);
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 0);
    idle(10);
    chk("rr_history_len", (hist_addr.size() >= 6) ? 1 : 0, 1);
    for (int i = 0; i < 6; i++) chk($sformatf("rr_addr%0d", i), hist_addr[i], exp_rr[i]);

    // Stop, drain, then start together with stop in IDLE.
    cyc(1'b0, 1'b1, 1'b0, 0, 0, 0);
    idle(4);
    chk("drain_flushed", exp_q.size(), 0);
    cyc(1'b1, 1'b1, 1'b0, 0, 0, 0);
    idle(3);

    // Wrap-around: ch0 step 0xF8 walks the table downwards.
    cyc(1'b0, 1'b0, 1'b1, 0, 'hF8, 0);
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 0);
    idle(9);
    for (int i = 0; i < 4; i++) chk($sformatf("wrap_ch0_addr%0d", i), hist_addr[2*i], exp_wrap[i]);
    cyc(1'b0, 1'b1, 1'b0, 0, 0, 0);
    idle(4);

    // Config collision: ch1 step 16 -> 32 written in a ch1 issue cycle.
    cyc(1'b0, 1'b0, 1'b1, 0, 8, 0);
    cyc(1'b0, 1'b0, 1'b1, 1, 16, 0);
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 0);
    idle(1);
    cyc(1'b0, 1'b0, 1'b1, 1, 32, 0);
    idle(8);
    for (int i = 0; i < 4; i++) chk($sformatf("collision_ch1_addr%0d", i), hist_addr[2*i+1], exp_col[i]);

    // Reset in the middle of a run; nothing may come out afterwards until restarted.
    do_reset(3);
    idle(4);
    cyc(1'b0, 1'b0, 1'b1, 0, 40, 0);
    cyc(1'b0, 1'b0, 1'b1, 1, 24, 0);
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 0);
    idle(6);
    cyc(1'b0, 1'b1, 1'b0, 0, 0, 0);
    idle(4);

`ifdef WAVE_SEQ_PHASE_OFFSET_EN
    cyc(1'b0, 1'b0, 1'b1, 1, 16, 'h80);
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 0);
    idle(3);
    chk("offset_first_ch1_addr", hist_addr[1], 16);
    cyc(1'b0, 1'b1, 1'b0, 0, 0, 0);
    idle(4);
`endif

    // Random start/stop/config traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 8) == 0, ($urandom % 16) == 0, ($urandom % 3) == 0,
          int'($urandom % CHANNELS), int'($urandom % ACC_MOD), int'($urandom % ACC_MOD));
    end
    cyc(1'b0, 1'b1, 1'b0, 0, 0, 0);
    idle(5);

    chk("final_queue_empty", exp_q.size(), 0);
    chk("samples_seen_vs_issued", n_seen, n_issued);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
